sine_ref_ramp_ctrl: RTL and testbench

// Soft-start/soft-stop sequencer for the sine reference generator of the 5-level inverter.

---
 rtl/sine_ctrl_pkg.sv | 19 +
 rtl/ramp_tick_gen.sv | 33 +++
 rtl/sine_ref_ramp_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sine_ref_ramp_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_ctrl_pkg.sv
// Shared types and constants for the sine reference
// soft-start/soft-stop sequencer.
package sine_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_EN  = 3'd1,
    RAMP_UP   = 3'd2,
    RUN       = 3'd3,
    RAMP_DN   = 3'd4,
    STOP_WAIT = 3'd5
  } state_e;

  localparam int unsigned MI_FULL_SCALE = 32767;

  localparam logic [31:0] START_FREQ_INC_DEFAULT =
    32'h00A3D70A;

endpackage

// File: rtl/ramp_tick_gen.sv
// Step-rate prescaler: one tick every DIV clocks
// while run is high; clr restarts the count.
module ramp_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign tick = run & ~clr & last;

endmodule

// File: rtl/sine_ref_ramp_ctrl.sv
// Soft-start/soft-stop sequencer slewing the sine
// generator's enable, frequency and modulation index.
module sine_ref_ramp_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH     = 16,
  parameter int          PHASE_WIDTH    = 32,
  parameter int          LUT_ADDR_WIDTH = 8,
  parameter int unsigned RAMP_DIV       = 100000,
  parameter logic [PHASE_WIDTH-1:0] START_FREQ_INC =
    PHASE_WIDTH'(START_FREQ_INC_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [PHASE_WIDTH-1:0]    target_freq_inc,
  input  logic [DATA_WIDTH-1:0]     target_mi,
  input  logic [DATA_WIDTH-1:0]     mi_step,
  input  logic [PHASE_WIDTH-1:0]    freq_step,
  input  logic [LUT_ADDR_WIDTH-1:0] phase,
  output logic                      gen_enable,
  output logic [PHASE_WIDTH-1:0]    freq_increment,
  output logic [DATA_WIDTH-1:0]     modulation_index,
  output logic [2:0]                state_o,
  output logic                      at_target
);

  localparam int DW1 = DATA_WIDTH + 1;
  localparam int PW1 = PHASE_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] MI_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_e                  state, state_n;
  logic [DATA_WIDTH-1:0]   mi_q, mi_n, tgt_mi;
  logic [PHASE_WIDTH-1:0]  freq_q, freq_n;
  logic                    en_q, en_n;
  logic                    at_tgt_q, at_tgt_n;
  logic                    phase_msb_q;
  logic                    wrap;
  logic                    tick;
  logic                    run;
  logic                    clr;
  logic                    unused_phase_lsbs;

  // Saturating move of x toward t; a zero step counts
  // as one. The extra bit keeps the distance exact.
  function automatic logic [DATA_WIDTH-1:0] slew_mi(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] t,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH:0] st, d, r;
    st = (s == '0) ? DW1'(1) : {1'b0, s};
    if (t >= x) begin
      d = {1'b0, t} - {1'b0, x};
      r = (d <= st) ? {1'b0, t} : {1'b0, x} + st;
    end else begin
      d = {1'b0, x} - {1'b0, t};
      r = (d <= st) ? {1'b0, t} : {1'b0, x} - st;
    end
    return DATA_WIDTH'(r);
  endfunction

  function automatic logic [PHASE_WIDTH-1:0] slew_freq(
    input logic [PHASE_WIDTH-1:0] x,
    input logic [PHASE_WIDTH-1:0] t,
    input logic [PHASE_WIDTH-1:0] s
  );
    logic [PHASE_WIDTH:0] st, d, r;
    st = (s == '0) ? PW1'(1) : {1'b0, s};
    if (t >= x) begin
      d = {1'b0, t} - {1'b0, x};
      r = (d <= st) ? {1'b0, t} : {1'b0, x} + st;
    end else begin
      d = {1'b0, x} - {1'b0, t};
      r = (d <= st) ? {1'b0, t} : {1'b0, x} - st;
    end
    return PHASE_WIDTH'(r);
  endfunction

  assign tgt_mi = (target_mi > MI_MAX) ? MI_MAX
                                       : target_mi;

  assign wrap = phase_msb_q & ~phase[LUT_ADDR_WIDTH-1];
  assign unused_phase_lsbs = ^phase[LUT_ADDR_WIDTH-2:0];

  assign run = (state != IDLE);
  assign clr = (state == IDLE) || (state == START_EN);

  ramp_tick_gen #(
    .DIV (RAMP_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    mi_n    = mi_q;
    freq_n  = freq_q;
    en_n    = en_q;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = START_EN;
          freq_n  = START_FREQ_INC;
          mi_n    = '0;
          en_n    = 1'b1;
        end
      end
      START_EN: begin
        state_n = stop ? RAMP_DN : RAMP_UP;
      end
      RAMP_UP: begin
        if (stop) begin
          state_n = RAMP_DN;
        end else if (tick) begin
          mi_n   = slew_mi(mi_q, tgt_mi, mi_step);
          freq_n = slew_freq(freq_q, target_freq_inc,
                             freq_step);
          if (mi_n == tgt_mi &&
              freq_n == target_freq_inc) begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = RAMP_DN;
        end else if (tick) begin
          mi_n   = slew_mi(mi_q, tgt_mi, mi_step);
          freq_n = slew_freq(freq_q, target_freq_inc,
                             freq_step);
        end
      end
      RAMP_DN: begin
        if (tick) begin
          mi_n = slew_mi(mi_q, '0, mi_step);
          if (mi_n == '0) begin
            state_n = STOP_WAIT;
          end
        end
      end
      STOP_WAIT: begin
        // Disable only on a fundamental-cycle boundary.
        if (wrap) begin
          state_n = IDLE;
          en_n    = 1'b0;
          freq_n  = '0;
          mi_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        en_n    = 1'b0;
        freq_n  = '0;
        mi_n    = '0;
      end
    endcase
    at_tgt_n = (state_n == RUN) &&
               (mi_n == tgt_mi) &&
               (freq_n == target_freq_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mi_q        <= '0;
      freq_q      <= '0;
      en_q        <= 1'b0;
      at_tgt_q    <= 1'b0;
      phase_msb_q <= 1'b0;
    end else begin
      state       <= state_n;
      mi_q        <= mi_n;
      freq_q      <= freq_n;
      en_q        <= en_n;
      at_tgt_q    <= at_tgt_n;
      phase_msb_q <= phase[LUT_ADDR_WIDTH-1];
    end
  end

  assign gen_enable       = en_q;
  assign freq_increment   = freq_q;
  assign modulation_index = mi_q;
  assign state_o          = state;
  assign at_target        = at_tgt_q;

endmodule

// File: tb/tb_sine_ref_ramp_ctrl.sv
// Bench for sine_ref_ramp_ctrl: scenario tasks against
// a saturating-slew reference model, RAMP_DIV=4.
module tb_sine_ref_ramp_ctrl;

  localparam int DIV = 4;
  localparam logic [31:0] SFI = 32'h00A3D70A;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DN    = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic        clk, rst_n, start, stop;
  logic [31:0] target_freq_inc, freq_step;
  logic [15:0] target_mi, mi_step;
  logic [7:0]  phase;
  logic        gen_enable, at_target;
  logic [31:0] freq_increment;
  logic [15:0] modulation_index;
  logic [2:0]  state_o;

  int          checks, errors, cyc, grid;
  logic [7:0]  ph_inc, ph_last, ph_last2;
  longint      m_mi, m_freq;

  sine_ref_ramp_ctrl #(
    .DATA_WIDTH     (16),
    .PHASE_WIDTH    (32),
    .LUT_ADDR_WIDTH (8),
    .RAMP_DIV       (DIV),
    .START_FREQ_INC (SFI)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stop             (stop),
    .target_freq_inc  (target_freq_inc),
    .target_mi        (target_mi),
    .mi_step          (mi_step),
    .freq_step        (freq_step),
    .phase            (phase),
    .gen_enable       (gen_enable),
    .freq_increment   (freq_increment),
    .modulation_index (modulation_index),
    .state_o          (state_o),
    .at_target        (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint clamp_mi(longint t);
    return (t > 32767) ? 32767 : t;
  endfunction

  function automatic longint slew(longint x, longint t,
                                  longint s);
    longint st;
    st = (s == 0) ? 1 : s;
    if (t > x) return (t - x <= st) ? t : x + st;
    return (x - t <= st) ? t : x - st;
  endfunction

  function automatic longint tmi();
    return clamp_mi(longint'(target_mi));
  endfunction

  task automatic clk1;
    ph_last2 = ph_last;
    ph_last  = phase;
    @(posedge clk);
    cyc++;
    #1;
    phase = phase + ph_inc;
  endtask

  task automatic to_tick;
    do clk1; while (((cyc - grid) % DIV) != 0);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ph_last = 8'd0;
  endtask

  task automatic do_start;
    start = 1'b1; clk1; start = 1'b0;
    clk1;
    grid = cyc;
    m_mi = 0; m_freq = SFI;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gen_enable, at_target, state_o} !== 5'd0 ||
        freq_increment !== 32'd0 ||
        modulation_index !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: en=%b at=%b st=%0d f=%h mi=%0d want all 0",
               gen_enable, at_target, state_o,
               freq_increment, modulation_index);
    end
    apply_reset;
    repeat (3) clk1;
    checks++;
    if ({gen_enable, at_target, state_o} !== 5'd0 ||
        freq_increment !== 32'd0 ||
        modulation_index !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: en=%b st=%0d f=%h mi=%0d want all 0",
               gen_enable, state_o, freq_increment,
               modulation_index);
    end
  endtask

  task automatic test_ramp_up;
    target_mi = 16'd1000; mi_step = 16'd300;
    target_freq_inc = SFI;
    freq_step = 32'($urandom_range(0, 50));
    start = 1'b1; clk1; start = 1'b0;
    checks++;
    if (gen_enable !== 1'b1 || state_o !== S_START) begin
      errors++;
      $display("FAIL start_en: en=%b st=%0d want en=1 st=1",
               gen_enable, state_o);
    end
    checks++;
    if (freq_increment !== SFI ||
        modulation_index !== 16'd0) begin
      errors++;
      $display("FAIL start_load: f=%h mi=%0d want f=%h mi=0",
               freq_increment, modulation_index, SFI);
    end
    clk1;
    grid = cyc;
    checks++;
    if (state_o !== S_UP) begin
      errors++;
      $display("FAIL enter_ramp_up: st=%0d want 2", state_o);
    end
    m_mi = 0; m_freq = SFI;
    for (int k = 0; k < 8; k++) begin
      to_tick;
      m_mi = slew(m_mi, tmi(), longint'(mi_step));
      m_freq = slew(m_freq, longint'(target_freq_inc),
                    longint'(freq_step));
      checks++;
      if (modulation_index !== 16'(m_mi)) begin
        errors++;
        $display("FAIL ramp_mi: got %0d want %0d",
                 modulation_index, m_mi);
      end
      checks++;
      if (state_o !== ((m_mi == 1000) ? S_RUN : S_UP) ||
          at_target !== (m_mi == 1000)) begin
        errors++;
        $display("FAIL ramp_state: st=%0d at=%b mi=%0d",
                 state_o, at_target, m_mi);
      end
      if (k == 0) begin
        clk1;
        checks++;
        if (modulation_index !== 16'd300) begin
          errors++;
          $display("FAIL hold_between_ticks: got %0d want 300",
                   modulation_index);
        end
      end
      if (m_mi == 1000) break;
    end
  endtask

  task automatic test_freq_slew;
    longint tf;
    tf = longint'(SFI) + 10;
    target_freq_inc = 32'(tf); freq_step = 32'd4;
    clk1;
    checks++;
    if (at_target !== 1'b0 || freq_increment !== SFI) begin
      errors++;
      $display("FAIL freq_mismatch: at=%b f=%h want at=0 f=%h",
               at_target, freq_increment, SFI);
    end
    for (int k = 0; k < 8; k++) begin
      to_tick;
      m_freq = slew(m_freq, tf, 4);
      checks++;
      if (freq_increment !== 32'(m_freq) ||
          at_target !== (m_freq == tf) ||
          modulation_index !== 16'd1000 ||
          state_o !== S_RUN) begin
        errors++;
        $display("FAIL freq_slew: f=%h at=%b mi=%0d st=%0d want f=%h at=%b",
                 freq_increment, at_target, modulation_index,
                 state_o, 32'(m_freq), (m_freq == tf));
      end
      if (m_freq == tf) break;
    end
  endtask

  task automatic test_random_run;
    longint tf;
    bit     done;
    for (int r = 0; r < 6; r++) begin
      target_mi = 16'($urandom_range(0, 65535));
      mi_step   = 16'($urandom_range(2000, 40000));
      if ($urandom_range(0, 3) == 0) begin
        freq_step = 32'd0;
        tf = m_freq + $urandom_range(0, 8) - 4;
      end else begin
        freq_step = 32'($urandom_range(5, 60));
        tf = m_freq + $urandom_range(0, 200) - 100;
      end
      target_freq_inc = 32'(tf);
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
        to_tick;
        m_mi = slew(m_mi, tmi(), longint'(mi_step));
        m_freq = slew(m_freq, tf, longint'(freq_step));
        done = (m_mi == tmi()) && (m_freq == tf);
        checks++;
        if (modulation_index !== 16'(m_mi) ||
            freq_increment !== 32'(m_freq) ||
            at_target !== done || state_o !== S_RUN) begin
          errors++;
          $display("FAIL rand_run[%0d]: mi=%0d f=%h at=%b st=%0d want mi=%0d f=%h at=%b",
                   r, modulation_index, freq_increment,
                   at_target, state_o, m_mi,
                   32'(m_freq), done);
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL rand_run_timeout[%0d]: targets not reached",
                 r);
      end
    end
  endtask

  task automatic test_stop;
    bit done;
    target_mi = 16'd1000; mi_step = 16'd40000;
    target_freq_inc = SFI + 32'd10;
    freq_step = 32'hFFFF_FFFF;
    to_tick;
    m_mi = 1000; m_freq = longint'(SFI) + 10;
    checks++;
    if (modulation_index !== 16'd1000 ||
        freq_increment !== SFI + 32'd10 ||
        at_target !== 1'b1) begin
      errors++;
      $display("FAIL stop_settle: mi=%0d f=%h at=%b want 1000/%h/1",
               modulation_index, freq_increment, at_target,
               SFI + 32'd10);
    end
    mi_step = 16'd300; ph_inc = 8'd1;
    stop = 1'b1; clk1; stop = 1'b0;
    checks++;
    if (state_o !== S_DN || modulation_index !== 16'd1000) begin
      errors++;
      $display("FAIL stop_enter: st=%0d mi=%0d want st=4 mi=1000",
               state_o, modulation_index);
    end
    for (int k = 0; k < 8; k++) begin
      to_tick;
      m_mi = slew(m_mi, 0, 300);
      checks++;
      if (modulation_index !== 16'(m_mi) ||
          freq_increment !== 32'(m_freq) ||
          gen_enable !== 1'b1 ||
          state_o !== ((m_mi == 0) ? S_WAIT : S_DN)) begin
        errors++;
        $display("FAIL ramp_dn: mi=%0d f=%h en=%b st=%0d want mi=%0d",
                 modulation_index, freq_increment,
                 gen_enable, state_o, m_mi);
      end
      if (m_mi == 0) break;
    end
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      clk1;
      if (ph_last2[7] && !ph_last[7]) begin
        done = 1'b1;
        checks++;
        if (gen_enable !== 1'b0 || state_o !== S_IDLE ||
            freq_increment !== 32'd0 ||
            modulation_index !== 16'd0 ||
            at_target !== 1'b0) begin
          errors++;
          $display("FAIL stop_idle: en=%b st=%0d f=%h mi=%0d want 0/0/0/0",
                   gen_enable, state_o, freq_increment,
                   modulation_index);
        end
      end else begin
        checks++;
        if (gen_enable !== 1'b1 || state_o !== S_WAIT) begin
          errors++;
          $display("FAIL stop_wait: en=%b st=%0d want en=1 st=5 ph=%h",
                   gen_enable, state_o, ph_last);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stop_wrap_timeout: no phase wrap seen");
    end
    ph_inc = 8'd7;
  endtask

  task automatic test_saturate;
    logic [15:0] tms [3] = '{16'hFFFF, 16'd32760, 16'd0};
    logic [15:0] mss [3] = '{16'd40000, 16'd0, 16'hFFFF};
    logic [31:0] tfs [3] = '{SFI, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] fss [3] = '{32'd3, 32'hF000_0000,
                             32'hF000_0000};
    bit done;
    target_mi = tms[0]; mi_step = mss[0];
    target_freq_inc = tfs[0]; freq_step = fss[0];
    do_start;
    for (int s = 0; s < 3; s++) begin
      target_mi = tms[s]; mi_step = mss[s];
      target_freq_inc = tfs[s]; freq_step = fss[s];
      done = 1'b0;
      for (int k = 0; k < 16; k++) begin
        to_tick;
        m_mi = slew(m_mi, tmi(), longint'(mi_step));
        m_freq = slew(m_freq, longint'(tfs[s]),
                      longint'(freq_step));
        checks++;
        if (modulation_index !== 16'(m_mi) ||
            freq_increment !== 32'(m_freq) ||
            state_o !== S_RUN) begin
          errors++;
          $display("FAIL saturate[%0d]: mi=%0d f=%h st=%0d want mi=%0d f=%h st=3",
                   s, modulation_index, freq_increment,
                   state_o, m_mi, 32'(m_freq));
        end
        if (done) break;
        done = (m_mi == tmi()) &&
               (m_freq == longint'(tfs[s]));
      end
    end
  endtask

  task automatic test_start_stop;
    apply_reset;
    start = 1'b1; stop = 1'b1; clk1;
    start = 1'b0; stop = 1'b0;
    repeat (3) clk1;
    checks++;
    if (state_o !== S_IDLE || gen_enable !== 1'b0 ||
        freq_increment !== 32'd0) begin
      errors++;
      $display("FAIL start_and_stop: st=%0d en=%b f=%h want idle",
               state_o, gen_enable, freq_increment);
    end
    target_mi = 16'd1000; mi_step = 16'd300;
    target_freq_inc = SFI;
    do_start;
    repeat (2) begin
      to_tick;
      m_mi = slew(m_mi, tmi(), 300);
    end
    stop = 1'b1; clk1; stop = 1'b0;
    checks++;
    if (state_o !== S_DN || modulation_index !== 16'(m_mi)) begin
      errors++;
      $display("FAIL stop_in_ramp_up: st=%0d mi=%0d want st=4 mi=%0d",
               state_o, modulation_index, m_mi);
    end
    start = 1'b1; clk1; start = 1'b0;
    checks++;
    if (state_o !== S_DN) begin
      errors++;
      $display("FAIL start_ignored: st=%0d want 4", state_o);
    end
    for (int k = 0; k < 4; k++) begin
      to_tick;
      m_mi = slew(m_mi, 0, 300);
      checks++;
      if (modulation_index !== 16'(m_mi) ||
          state_o !== ((m_mi == 0) ? S_WAIT : S_DN)) begin
        errors++;
        $display("FAIL dn_from_ramp: mi=%0d st=%0d want mi=%0d",
                 modulation_index, state_o, m_mi);
      end
      if (m_mi == 0) break;
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    target_mi = 16'd5000; mi_step = 16'd300;
    target_freq_inc = SFI + 32'd50;
    freq_step = 32'd1;
    do_start;
    to_tick; to_tick;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gen_enable, at_target, state_o} !== 5'd0 ||
        freq_increment !== 32'd0 ||
        modulation_index !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b st=%0d f=%h mi=%0d want all 0",
               gen_enable, state_o, freq_increment,
               modulation_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ph_last = 8'd0;
    do_start;
    to_tick;
    checks++;
    if (modulation_index !== 16'd300 ||
        freq_increment !== SFI + 32'd1 ||
        state_o !== S_UP) begin
      errors++;
      $display("FAIL restart: mi=%0d f=%h st=%0d want 300/%h/2",
               modulation_index, freq_increment, state_o,
               SFI + 32'd1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; grid = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    target_mi = '0; mi_step = '0;
    target_freq_inc = '0; freq_step = '0;
    phase = 8'($urandom);
    ph_inc = 8'd7; ph_last = '0; ph_last2 = '0;
    m_mi = 0; m_freq = 0;
    test_reset;
    test_ramp_up;
    test_freq_slew;
    test_random_run;
    test_stop;
    test_saturate;
    test_start_stop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
